mem_arbiter: RTL
================

# mem_arbiter

Two-master arbiter that shares the single data port of the unified RAM between the CPU data bus and a second master (debug/program loader or DMA). Sits between the CPU data-side signals and the RAM's data port (`a2`/`di2`/`do2`/`m2`/`we2`) in the Von-Neumann build; the instruction port is untouched. Grants are registered, round-robin on contention, with an optional lock for master 1 bounded by a burst limit.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_BURST`, 8, maximum consecutive locked beats for m1 while m0 is waiting; must be ≥1

Ports:
- `clk` in 1, system clock
- `reset` in 1, asynchronous, active-low reset (`reset`=0 resets)
- `m0_req`, `m0_we` in 1; `m0_mask` in 4; `m0_addr` in ADDR_W; `m0_wdata` in DATA_W: CPU request
- `m0_rdata` out DATA_W; `m0_ready` out 1: CPU response
- `m1_req`, `m1_we`, `m1_lock` in 1; `m1_mask` in 4; `m1_addr` in ADDR_W; `m1_wdata` in DATA_W: master-1 request
- `m1_rdata` out DATA_W; `m1_ready` out 1: master-1 response
- `s_addr` out ADDR_W; `s_wdata` out DATA_W; `s_mask` out 4; `s_we` out 1: to RAM data port
- `s_rdata` in DATA_W: combinational read data from RAM
- `owner` out 2: 00 idle, 01 m0, 10 m1

## Operation
- FSM states: IDLE, OWN0, OWN1. State drives `owner`.
- In OWNx, slave outputs are muxed from master x: `s_addr`/`s_wdata`/`s_mask` = mx fields; `s_we` = `mx_req & mx_we`. In IDLE, all slave outputs are 0.
- `mx_ready` = (state==OWNx) & `mx_req`. A beat completes on every ready cycle. A write commits at that clock edge; read data is valid the same cycle.
- `mx_rdata` = `s_rdata` while OWNx, else 0.
- Round-robin pointer `last` (1 bit) records the last master granted. Reset value is 1, so m0 wins the first tie.
- From IDLE:
  - both requesting → grant master ≠ `last`
  - only one requesting → grant it
  - neither → stay in IDLE
- From OWNx at each edge:
  - other master requesting and switch allowed → OWN(other)
  - else current still requesting → stay
  - else other requesting → OWN(other)
  - else → IDLE
- Switch allowed:
  - always when owner is m0
  - for m1: when `m1_lock`=0, or burst counter == MAX_BURST
- Burst counter:
  - increments on each completed m1 beat while m0_req=1
  - saturates at MAX_BURST
  - clears on any state change and when m0_req=0
- `last` updates on every transition into OWNx.
- Master must hold `req` and all request fields stable until `ready`. A request dropped before ready is abandoned: no write, no side effect.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `owner`=00, `last`=1, counter 0, all outputs 0. `s_we` drops combinationally, so a reset mid-write never commits.
- Latency:
  - from IDLE: req at cycle N → ready at N+1
  - owner stays: back-to-back beats, one per cycle
  - contention without lock: beats alternate m0/m1 every cycle
- Locked m1 with m0 waiting: m1 gets MAX_BURST+1 beats at most, then m0 is granted next cycle.
- Simultaneous first requests after reset: m0 granted.

## Structure
- Shared package/header (`constants.vh`): state encodings, `owner` encodings.
- Counter is a natural sub-module: `sat_counter` (width from `$clog2(MAX_BURST+1)`, inc/clr, saturating). FSM and muxes live in `mem_arbiter`.

## Test plan
- Reset, then m0 write addr 0x10, data 0xDEADBEEF, mask 4'hF at cycle 1 → `m0_ready`=1 at cycle 2, `s_we`=1, `owner`=01; m0 read of 0x10 returns 0xDEADBEEF.
- m0 and m1 request together from IDLE after reset → m0 served first. With both held, ready alternates m0, m1, m0, m1.
- m1 locked burst of 20 writes, m0 requesting from the start, MAX_BURST=8 → m1 gets 9 consecutive beats, then m0 is granted on the following cycle.
- m1 drops req before its grant cycle → no `s_we` pulse, FSM returns to IDLE, memory unchanged.
- Assert `reset`=0 mid-cycle while m1 is writing (`s_we`=1) → `s_we`=0 immediately, target word keeps its old value, `owner`=00.
- Partial write: m1 mask 4'b0010, data 0x0000AB00 over 0x11223344 → read back 0x1122AB44.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-master RAM data-port arbiter.
package mem_arbiter_pkg;

    localparam logic [1:0] OWNER_IDLE = 2'b00;
    localparam logic [1:0] OWNER_M0   = 2'b01;
    localparam logic [1:0] OWNER_M1   = 2'b10;

    // The state encoding is the owner output, so no decode is needed.
    typedef enum logic [1:0] {
        ST_IDLE = OWNER_IDLE,
        ST_OWN0 = OWNER_M0,
        ST_OWN1 = OWNER_M1
    } state_e;

    function automatic state_e own_state(input logic sel_m1);
        return sel_m1 ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; counts locked m1 beats.
module mem_arbiter_sat_counter #(
    parameter int MAX_VAL = 8,
    parameter int WIDTH   = $clog2(MAX_VAL + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;

    // NOTE: assign the default first so every path writes count_d and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != MAX_CNT)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Registered round-robin arbiter sharing the RAM data port between the CPU (m0) and a second master (m1).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [3:0]        m0_mask,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [3:0]        m1_mask,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,

    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [3:0]        s_mask,
    output logic              s_we,
    input  logic [DATA_W-1:0] s_rdata,

    output logic [1:0]        owner
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] burst_cnt;
    logic             burst_full;
    logic             switch_ok;
    logic             cnt_inc, cnt_clr;

    // A locked m1 may only be pre-empted once it has used up its burst allowance.
    assign burst_full = (burst_cnt == CNT_W'(MAX_BURST));
    assign switch_ok  = !m1_lock || burst_full;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_req && m1_req) begin
                    state_d = own_state(!last_q);
                end else if (m0_req) begin
                    state_d = ST_OWN0;
                end else if (m1_req) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (m1_req) begin
                    state_d = ST_OWN1;
                end else if (!m0_req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (m0_req && switch_ok) begin
                    state_d = ST_OWN0;
                end else if (m1_req) begin
                    state_d = ST_OWN1;
                end else if (m0_req) begin
                    state_d = ST_OWN0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (state_d != state_q) begin
            if (state_d == ST_OWN0) begin
                last_d = 1'b0;
            end else if (state_d == ST_OWN1) begin
                last_d = 1'b1;
            end
        end
    end

    assign cnt_inc = (state_q == ST_OWN1) && m1_req && m0_req;
    assign cnt_clr = (state_d != state_q) || !m0_req;

    mem_arbiter_sat_counter #(
        .MAX_VAL (MAX_BURST),
        .WIDTH   (CNT_W)
    ) u_burst_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (cnt_inc),
        .clr_i   (cnt_clr),
        .count_o (burst_cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Data path is purely combinational from the registered owner, so reset kills s_we at once.
    always_comb begin
        s_addr   = '0;
        s_wdata  = '0;
        s_mask   = '0;
        s_we     = 1'b0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        case (state_q)
            ST_OWN0: begin
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_mask   = m0_mask;
                s_we     = m0_req && m0_we;
                m0_ready = m0_req;
                m0_rdata = s_rdata;
            end
            ST_OWN1: begin
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_mask   = m1_mask;
                s_we     = m1_req && m1_we;
                m1_ready = m1_req;
                m1_rdata = s_rdata;
            end
            default: ;
        endcase
    end

    assign owner = state_q;

endmodule
